// File: rtl/mult_rep_add_seq_pkg.sv
// Shared types and helpers for the repeated-addition multiplier.
// Holds the FSM state encoding, width helpers and the operand magnitude function.
package mult_rep_add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int MAX_W     = 32;
  localparam int PW        = 2 * DEF_WIDTH;

  function automatic int pw_f(input int w);
    return 2 * w;
  endfunction

  // The magnitude of the most negative value, -2^(w-1), is 2^(w-1), which still fits in w bits.
  function automatic logic [MAX_W-1:0] mag_f(input logic [MAX_W-1:0] v,
                                             input int              w,
                                             input bit              signed_op);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] sh;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    sh   = v >> (w - 1);
    if (signed_op && sh[0]) begin
      return ((~v) + MAX_W'(1)) & mask;
    end
    return v & mask;
  endfunction

endpackage

// File: rtl/mult_rep_add_seq_if.sv
// Request/response bundle between a requester and the repeated-addition multiplier.
interface mult_rep_add_seq_if
  import mult_rep_add_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic                 start;
  logic                 abort;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, abort, a, b,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, abort, a, b,
    output ready, busy, done, product
  );
endinterface

// File: rtl/mult_rep_add_seq_add_w.sv
// Parametrised combinational adder; generalisation of the former fixed 16-bit adder.
module add_w #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = in1_i + in2_i;

endmodule

// File: rtl/mult_rep_add_seq.sv
// Sequential multiplier by repeated addition: one addend accumulation per cycle,
// with signed support, shortest-loop operand swap, zero short-cut and abort.
module mult_rep_add_seq
  import mult_rep_add_seq_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SIGNED_MODE = 0,
  parameter int SWAP_MIN    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_rep_add_seq_if.slave  bus
);

  localparam int ACC_W = pw_f(WIDTH);

  state_e               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     addend_q, addend_d;
  logic                 neg_q, neg_d;
  logic [ACC_W-1:0]     product_q, product_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     cnt_sel, addend_sel;
  logic                 neg_sel;
  logic [ACC_W-1:0]     sum;

  add_w #(
    .WIDTH (ACC_W)
  ) u_acc_add (
    .in1_i (acc_q),
    .in2_i ({{WIDTH{1'b0}}, addend_q}),
    .sum_o (sum)
  );

  always_comb begin
    mag_a      = WIDTH'(mag_f(MAX_W'(bus.a), WIDTH, SIGNED_MODE != 0));
    mag_b      = WIDTH'(mag_f(MAX_W'(bus.b), WIDTH, SIGNED_MODE != 0));
    neg_sel    = (SIGNED_MODE != 0) ? (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) : 1'b0;
    cnt_sel    = mag_b;
    addend_sel = mag_a;
    // Looping on the smaller magnitude bounds the latency by min(|a|,|b|).
    if (SWAP_MIN != 0 && mag_a < mag_b) begin
      cnt_sel    = mag_a;
      addend_sel = mag_b;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    addend_d  = addend_q;
    neg_d     = neg_q;
    product_d = product_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d    = '0;
          cnt_d    = cnt_sel;
          addend_d = addend_sel;
          neg_d    = neg_sel;
          if (cnt_sel == '0 || addend_sel == '0) begin
            product_d = '0;
            state_d   = DONE;
          end else begin
            state_d = ADD;
          end
        end
      end
      ADD: begin
        // Abort takes priority even on the final accumulation.
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q - WIDTH'(1);
          if (cnt_q == WIDTH'(1)) begin
            product_d = neg_q ? (~sum + ACC_W'(1)) : sum;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      addend_q  <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      addend_q  <= addend_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.busy    = (state_q == ADD) || (state_q == DONE);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;

endmodule
